paralelo_serial_phy_tx: RTL and testbench
=========================================

PARALELO_SERIAL_PHY_TX -- requirements
Module: paralelo_serial_phy_tx

Interface
REQ-001 The block SHALL have parameter COMMA, default 8'hBC, idle/sync character.
REQ-002 The block SHALL have parameter SYNC_COUNT, default 4, number of COMMA bytes sent after reset before data is accepted (legal range 1..15).
REQ-003 The block SHALL have port clk_32f  input  1  single bit clock; all logic is on its rising edge.
REQ-004 The block SHALL have port default_values  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port data_in  input  8  parallel byte to transmit.
REQ-006 The block SHALL have port valid_in  input  1  data_in holds a byte to send.
REQ-007 The block SHALL have port in_ready  output  1  byte-boundary accept strobe; transfer occurs when valid_in && in_ready.
REQ-008 The block SHALL have port data_out  output  1  serial stream, MSB first, one bit per clk_32f cycle.
REQ-009 The block SHALL have port active  output  1  preamble finished, link carrying data/idle.
REQ-010 The block SHALL have port tx_valid  output  1  the byte currently on data_out is a user byte, not an inserted COMMA.

Function
REQ-011 Timing reference: edge 0 SHALL be the first rising edge with default_values low; "cycle n" is the interval after edge n.
REQ-012 Byte k, bit i (i=0 is MSB) SHALL be driven on data_out in cycle 8k+i; an internal 3-bit bit counter wraps 7->0 with no gap between bytes.
REQ-013 The FSM SHALL have states SYNC and RUN; reset enters SYNC; SYNC->RUN at the edge starting byte SYNC_COUNT; RUN has no exit except reset.
REQ-014 In SYNC, bytes 0..SYNC_COUNT-1 SHALL be COMMA regardless of valid_in/data_in.
REQ-015 in_ready SHALL be high only in cycles 8k+7 for k >= SYNC_COUNT-1 (last bit of each byte preceding a RUN byte) and low otherwise.
REQ-016 If valid_in && in_ready in cycle 8k+7, data_in SHALL be captured at edge 8k+8 and transmitted as byte k+1, its MSB on data_out in cycle 8k+8 (zero bubble).
REQ-017 If valid_in is low while in_ready is high, byte k+1 SHALL be COMMA and tx_valid low for that byte.
REQ-018 valid_in and data_in SHALL be ignored when in_ready is low; X on them then SHALL not propagate to any output.
REQ-019 A captured user byte equal to COMMA SHALL be transmitted unchanged with tx_valid high.
REQ-020 tx_valid SHALL be high for all 8 cycles of a user byte and low for all 8 cycles of a COMMA byte.
REQ-021 active SHALL go high in cycle 8*SYNC_COUNT and stay high until reset.
REQ-022 The captured byte SHALL be held in an internal shift register so data_in may change from the cycle after capture.

Reset
REQ-023 While default_values is high at a rising edge, the next cycle SHALL show data_out=0, in_ready=0, active=0, tx_valid=0, bit counter=0, state=SYNC.
REQ-024 Reset asserted mid-byte SHALL abort that byte immediately; no partial byte resumes, and after release the full preamble of SYNC_COUNT COMMAs restarts at edge 0.
REQ-025 Reset SHALL take priority over a simultaneous valid_in && in_ready; the byte SHALL not be captured.

Verification
REQ-026 Preamble: release reset, valid_in=0 -> data_out = 10111100 repeated 4 times in cycles 0..31, in_ready first high cycle 31, active high from cycle 32, tx_valid=0 throughout.
REQ-027 Single byte: data_in=8'hA5, valid_in=1 in cycle 31 only -> cycles 32..39 data_out=1,0,1,0,0,1,0,1 with tx_valid=1, cycles 40..47 COMMA with tx_valid=0.
REQ-028 Back-to-back: valid_in=1 continuously, data_in=8'h01,8'h02,8'h03 changed after each strobe -> three contiguous bytes from cycle 32, no COMMA between, in_ready at 31,39,47.
REQ-029 Reset mid-operation: assert default_values for 1 cycle at cycle 35 -> outputs zero next cycle, then full 4-COMMA preamble, active low until 32 cycles after release.
REQ-030 Ignored input: valid_in=1, data_in=8'hFF held in cycles 0..30, then valid_in=0 -> only COMMA bytes transmitted, tx_valid never high.
REQ-031 Loopback: data_out into Serial_Paralelo_phy_rx on the same clk_32f, random bytes (excluding 8'hBC) with random idle gaps -> receiver active goes high and its data_out/valid sequence equals the accepted byte sequence in order.

Source files
------------

// File: rtl/paralelo_serial_phy_tx_if.sv
// Byte-side handshake and serial-side status bundle of the parallel-to-serial PHY transmitter.
interface paralelo_serial_phy_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       in_ready;
  logic       data_out;
  logic       active;
  logic       tx_valid;

  modport master (
    output data_in,
    output valid_in,
    input  in_ready,
    input  data_out,
    input  active,
    input  tx_valid
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output in_ready,
    output data_out,
    output active,
    output tx_valid
  );
endinterface

// File: rtl/paralelo_serial_phy_tx.sv
// Parallel-to-serial PHY transmitter: SYNC_COUNT COMMA bytes after reset, then
// MSB-first user bytes or COMMA idles with a zero-bubble byte-boundary handshake.
module paralelo_serial_phy_tx #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input logic                     clk_32f,
  input logic                     default_values,
  paralelo_serial_phy_tx_if.slave bus
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_bit_cnt;   // index of the bit loaded onto data_out at the next edge
  logic [2:0] w_bit_cnt_next;
  logic [3:0] r_sync_cnt;  // preamble bytes started so far
  logic [3:0] w_sync_cnt_next;
  logic [7:0] r_shift;
  logic [7:0] w_shift_next;
  logic       r_data_out;
  logic       w_data_out_next;
  logic       r_tx_valid;
  logic       w_tx_valid_next;
  logic       r_in_ready;
  logic       w_in_ready_next;
  logic       r_active;
  logic       w_active_next;
  logic [7:0] w_byte;
  logic       w_byte_user;

  // FSM state register
  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Serializer datapath and registered outputs
  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      r_bit_cnt  <= 3'd0;
      r_sync_cnt <= 4'd0;
      r_shift    <= 8'h00;
      r_data_out <= 1'b0;
      r_tx_valid <= 1'b0;
      r_in_ready <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_bit_cnt  <= w_bit_cnt_next;
      r_sync_cnt <= w_sync_cnt_next;
      r_shift    <= w_shift_next;
      r_data_out <= w_data_out_next;
      r_tx_valid <= w_tx_valid_next;
      r_in_ready <= w_in_ready_next;
      r_active   <= w_active_next;
    end
  end

  // Next-state, byte selection and shift logic
  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt + 3'd1;
    w_sync_cnt_next = r_sync_cnt;
    w_shift_next    = {r_shift[6:0], 1'b0};
    w_data_out_next = r_shift[7];
    w_tx_valid_next = r_tx_valid;
    w_active_next   = r_active;
    w_byte          = COMMA;
    w_byte_user     = 1'b0;

    if (r_bit_cnt == 3'd0) begin
      // in_ready is only ever high ahead of a RUN byte, so it alone gates capture
      if (r_in_ready && bus.valid_in) begin
        w_byte      = bus.data_in;
        w_byte_user = 1'b1;
      end else begin
        w_byte      = COMMA;
        w_byte_user = 1'b0;
      end

      case (r_state)
        ST_SYNC: begin
          if (r_sync_cnt == SYNC_LAST) begin
            w_state_next  = ST_RUN;
            w_active_next = 1'b1;
          end else begin
            w_sync_cnt_next = r_sync_cnt + 4'd1;
          end
        end
        ST_RUN: begin
          w_state_next = ST_RUN;
        end
        default: begin
          w_state_next = ST_SYNC;
        end
      endcase

      w_data_out_next = w_byte[7];
      w_shift_next    = {w_byte[6:0], 1'b0};
      w_tx_valid_next = w_byte_user;
    end else begin
      w_state_next = r_state;
    end

    if ((r_bit_cnt == 3'd7) && ((r_state == ST_RUN) || (r_sync_cnt == SYNC_LAST))) begin
      w_in_ready_next = 1'b1;
    end else begin
      w_in_ready_next = 1'b0;
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.tx_valid = r_tx_valid;
  assign bus.in_ready = r_in_ready;
  assign bus.active   = r_active;

endmodule

// File: tb/tb_paralelo_serial_phy_tx.sv
// Directed bench for paralelo_serial_phy_tx: preamble, single byte, back-to-back,
// ignored input, COMMA as user data and reset during operation.
module tb_paralelo_serial_phy_tx;
  localparam logic [7:0] COMMA = 8'hBC;

  logic clk_32f = 1'b0;
  logic default_values = 1'b1;
  int   checks = 0;
  int   failures = 0;

  paralelo_serial_phy_tx_if bus ();

  paralelo_serial_phy_tx #(.COMMA(COMMA), .SYNC_COUNT(4)) dut (
    .clk_32f        (clk_32f),
    .default_values (default_values),
    .bus            (bus)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic step();
    @(posedge clk_32f);
    #1;
  endtask

  // Leaves the bench one cycle after a reset edge; the next edge is edge 0.
  task automatic do_reset();
    default_values = 1'b1;
    bus.valid_in   = 1'b0;
    bus.data_in    = 8'h00;
    step();
    step();
    default_values = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.data_out !== 1'b0) begin failures++; $display("FAIL reset_data_out got=%b exp=0", bus.data_out); end
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++;
    if (bus.active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", bus.active); end
    checks++;
    if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
  endtask

  task automatic test_preamble();
    logic [7:0] exp_byte;
    logic       exp_rdy;
    exp_byte = COMMA;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      step();
      exp_rdy = ((c % 8) == 7) && (c >= 31);
      checks++;
      if (bus.data_out !== exp_byte[3'(7 - (c % 8))]) begin
        failures++; $display("FAIL preamble_data c=%0d got=%b exp=%b", c, bus.data_out, exp_byte[3'(7 - (c % 8))]);
      end
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        failures++; $display("FAIL preamble_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_rdy);
      end
      checks++;
      if (bus.active !== (c >= 32)) begin
        failures++; $display("FAIL preamble_active c=%0d got=%b exp=%b", c, bus.active, (c >= 32));
      end
      checks++;
      if (bus.tx_valid !== 1'b0) begin
        failures++; $display("FAIL preamble_tx_valid c=%0d got=%b exp=0", c, bus.tx_valid);
      end
    end
  endtask

  // One user byte offered in cycle 31 only; data_in is X outside that cycle.
  task automatic test_single(input logic [7:0] user);
    logic [7:0] exp_byte;
    logic       exp_user;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      step();
      bus.valid_in = (c == 31);
      bus.data_in  = (c == 31) ? user : 8'hxx;
      exp_user = (c >= 32) && (c < 40);
      exp_byte = exp_user ? user : COMMA;
      checks++;
      if (bus.data_out !== exp_byte[3'(7 - (c % 8))]) begin
        failures++; $display("FAIL single_%h_data c=%0d got=%b exp=%b", user, c, bus.data_out, exp_byte[3'(7 - (c % 8))]);
      end
      checks++;
      if (bus.tx_valid !== exp_user) begin
        failures++; $display("FAIL single_%h_tx_valid c=%0d got=%b exp=%b", user, c, bus.tx_valid, exp_user);
      end
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_byte;
    logic       exp_user;
    logic       exp_rdy;
    do_reset();
    for (int c = 0; c < 64; c++) begin
      step();
      bus.valid_in = (c < 48);
      bus.data_in  = (c < 32) ? 8'h01 : (c < 40) ? 8'h02 : (c < 48) ? 8'h03 : 8'h00;
      exp_user = (c >= 32) && (c < 56);
      exp_byte = (c < 32) ? COMMA : (c < 40) ? 8'h01 : (c < 48) ? 8'h02 : (c < 56) ? 8'h03 : COMMA;
      exp_rdy  = ((c % 8) == 7) && (c >= 31);
      checks++;
      if (bus.data_out !== exp_byte[3'(7 - (c % 8))]) begin
        failures++; $display("FAIL b2b_data c=%0d got=%b exp=%b", c, bus.data_out, exp_byte[3'(7 - (c % 8))]);
      end
      checks++;
      if (bus.tx_valid !== exp_user) begin
        failures++; $display("FAIL b2b_tx_valid c=%0d got=%b exp=%b", c, bus.tx_valid, exp_user);
      end
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        failures++; $display("FAIL b2b_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_rdy);
      end
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic test_ignored();
    logic [7:0] exp_byte;
    exp_byte = COMMA;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      step();
      bus.valid_in = (c <= 30);
      bus.data_in  = 8'hFF;
      checks++;
      if (bus.data_out !== exp_byte[3'(7 - (c % 8))]) begin
        failures++; $display("FAIL ignored_data c=%0d got=%b exp=%b", c, bus.data_out, exp_byte[3'(7 - (c % 8))]);
      end
      checks++;
      if (bus.tx_valid !== 1'b0) begin
        failures++; $display("FAIL ignored_tx_valid c=%0d got=%b exp=0", c, bus.tx_valid);
      end
    end
    bus.valid_in = 1'b0;
  endtask

  // Reset raised during cycle abort_c with a byte offered in cycle 31.
  task automatic test_reset_mid(input int abort_c);
    logic [7:0] exp_byte;
    exp_byte = COMMA;
    do_reset();
    for (int c = 0; c <= abort_c; c++) begin
      step();
      bus.valid_in = (c == 31);
      bus.data_in  = 8'h5A;
      if (c == abort_c) default_values = 1'b1;
    end
    step();
    checks++;
    if ({bus.data_out, bus.in_ready, bus.active, bus.tx_valid} !== 4'b0000) begin
      failures++; $display("FAIL abort%0d_zero got=%b exp=0000", abort_c, {bus.data_out, bus.in_ready, bus.active, bus.tx_valid});
    end
    default_values = 1'b0;
    bus.valid_in   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if (bus.data_out !== exp_byte[3'(7 - (c % 8))]) begin
        failures++; $display("FAIL abort%0d_data c=%0d got=%b exp=%b", abort_c, c, bus.data_out, exp_byte[3'(7 - (c % 8))]);
      end
      checks++;
      if (bus.active !== (c >= 32)) begin
        failures++; $display("FAIL abort%0d_active c=%0d got=%b exp=%b", abort_c, c, bus.active, (c >= 32));
      end
      checks++;
      if (bus.tx_valid !== 1'b0) begin
        failures++; $display("FAIL abort%0d_tx_valid c=%0d got=%b exp=0", abort_c, c, bus.tx_valid);
      end
    end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    test_reset();
    test_preamble();
    test_single(8'hA5);
    test_single(8'hBC);
    test_back_to_back();
    test_ignored();
    test_reset_mid(35);
    test_reset_mid(31);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
